alu_muldiv_seq: RTL and testbench

- Parametrised multi-cycle arithmetic unit that adds the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) alongside the single-cycle ALU.
- Iterative: one radix-2 shift-add or restoring-divide step per clock.
- Valid/ready handshake on both input and output. The execute stage stalls on in_ready/out_valid.

---
 rtl/alu_muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative RISC-V M-extension mul/div unit: one shift-add / restoring step per clock, DATA_WIDTH+1 edges
// (1 edge for divide special cases); result held in DONE until out_ready, in_ready only while IDLE.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(0);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(1);
  localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(2);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(4);
  localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(6);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [W-1:0]             mag_q, mag_d;
  logic [2*W-1:0]           acc_q, acc_d;
  logic                     neg_q, neg_d;
  logic                     rem_neg_q, rem_neg_d;
  logic [W-1:0]             result_q, result_d;

  // Request decode: operand magnitudes, signs and the divide early-outs
  logic         in_signed_a, in_signed_b;
  logic         in_sign_a, in_sign_b;
  logic [W-1:0] in_mag_a, in_mag_b;
  logic         in_is_div, in_div_zero, in_ovf;
  logic [W-1:0] in_special_res;

  always_comb begin
    in_signed_a    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                     (op == OP_DIV) || (op == OP_REM);
    in_signed_b    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    in_sign_a      = in_signed_a & src_a[W-1];
    in_sign_b      = in_signed_b & src_b[W-1];
    in_mag_a       = in_sign_a ? (~src_a + W'(1)) : src_a;
    in_mag_b       = in_sign_b ? (~src_b + W'(1)) : src_b;
    in_is_div      = op[2];
    in_div_zero    = in_is_div && (src_b == '0);
    in_ovf         = ((op == OP_DIV) || (op == OP_REM)) && (src_a == MOST_NEG) && (src_b == '1);
    in_special_res = '0;
    if (in_div_zero) begin
      in_special_res = op[1] ? src_a : '1;
    end else if (in_ovf) begin
      in_special_res = op[1] ? '0 : src_a;
    end
  end

  // One iteration step. acc holds {hi, lo}: for multiply lo is the multiplier being
  // shifted out; for divide hi is the partial remainder and lo the dividend/quotient.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] step_acc;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quot, rem;
  logic [W-1:0]   fin_result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_trial = acc_q[2*W-1:W-1] - {1'b0, mag_q};
    div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    step_acc  = op_q[2] ? div_next : mul_next;

    prod_s     = neg_q ? (~step_acc + (2*W)'(1)) : step_acc;
    quot       = step_acc[W-1:0];
    rem        = step_acc[2*W-1:W];
    fin_result = '0;
    if (!op_q[2]) begin
      fin_result = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    end else if (!op_q[1]) begin
      fin_result = neg_q ? (~quot + W'(1)) : quot;
    end else begin
      fin_result = rem_neg_q ? (~rem + W'(1)) : rem;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d      = op;
            neg_d     = in_sign_a ^ in_sign_b;
            rem_neg_d = in_sign_a;
            mag_d     = in_is_div ? in_mag_b : in_mag_a;
            acc_d     = {{W{1'b0}}, (in_is_div ? in_mag_a : in_mag_b)};
            cnt_d     = '0;
            if (in_div_zero || in_ovf) begin
              result_d = in_special_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_d = step_acc;
          if (cnt_q == CNT_LAST) begin
            result_d = fin_result;
            cnt_d    = '0;
            state_d  = S_DONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mag_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: hand-computed vectors per feature, checked inline.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Issues one request, scrambles the inputs after acceptance, waits (bounded) for out_valid.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit consume, output logic [W-1:0] res, output int edges,
                        output bit saw_rdy);
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    edges = 1; saw_rdy = 1'b0;
    in_valid = 1'b0; op = ~o; src_a = ~a; src_b = ~b;
    while (!out_valid && edges < 200) begin
      if (in_ready) saw_rdy = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    res = result;
    if (consume) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [W-1:0] r; int e; bit s;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1, r, e, s);
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
    checks++; if (e !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", e); end
    checks++; if (s !== 1'b0) begin failures++; $display("FAIL mul_in_ready_busy got=%b exp=0", s); end
  endtask

  task automatic test_mul_high();
    logic [2:0]   ops [6] = '{3'b001, 3'b011, 3'b010, 3'b001, 3'b001, 3'b000};
    logic [W-1:0] as  [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'hFFFF_FFFF};
    logic [W-1:0] exs [6] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [W-1:0] r; int e; bit s;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b1, r, e, s);
      checks++; if (r !== exs[i]) begin failures++; $display("FAIL mulh_result[%0d] got=%h exp=%h", i, r, exs[i]); end
      checks++; if (e !== 33) begin failures++; $display("FAIL mulh_latency[%0d] got=%0d exp=33", i, e); end
    end
  endtask

  task automatic test_div();
    logic [2:0]   ops [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
    logic [W-1:0] as  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h8000_0000};
    logic [W-1:0] bs  [7] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [W-1:0] exs [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1,
                              32'hFFFF_FFF2, 32'd2, 32'd0};
    logic [W-1:0] r; int e; bit s;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b1, r, e, s);
      checks++; if (r !== exs[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, r, exs[i]); end
      checks++; if (e !== 33) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, e); end
    end
  endtask

  task automatic test_special();
    logic [2:0]   ops [7] = '{3'b100, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110, 3'b110};
    logic [W-1:0] as  [7] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [W-1:0] bs  [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] exs [7] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
    logic [W-1:0] r; int e; bit s;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b1, r, e, s);
      checks++; if (r !== exs[i]) begin failures++; $display("FAIL special_result[%0d] got=%h exp=%h", i, r, exs[i]); end
      checks++; if (e !== 1) begin failures++; $display("FAIL special_latency[%0d] got=%0d exp=1", i, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; int e; bit s;
    run_op(3'b000, 32'd3, 32'd4, 1'b0, r, e, s);
    checks++; if (r !== 32'd12) begin failures++; $display("FAIL bp_result got=%h exp=c", r); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'b101; src_a = 32'd50; src_b = 32'd5;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (result !== 32'd12) begin failures++; $display("FAIL bp_hold[%0d] got=%h exp=c", i, result); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_flush();
    logic [W-1:0] r; int e; bit s; bit seen_valid;
    @(negedge clk);
    op = 3'b000; src_a = 32'd5; src_b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL flush_no_valid got=%b exp=0", seen_valid); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_accept got=%b exp=0", busy); end
    run_op(3'b101, 32'd100, 32'd7, 1'b1, r, e, s);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL flush_next_result got=%h exp=e", r); end
    checks++; if (e !== 33) begin failures++; $display("FAIL flush_next_latency got=%0d exp=33", e); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] r; int e; bit s;
    @(negedge clk);
    op = 3'b000; src_a = 32'd2; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (result !== '0) begin failures++; $display("FAIL arst_result got=%h exp=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b011, 32'h0001_0000, 32'h0001_0000, 1'b1, r, e, s);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL arst_next_result got=%h exp=1", r); end
    checks++; if (e !== 33) begin failures++; $display("FAIL arst_next_latency got=%0d exp=33", e); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
